// File: rtl/m1_output_5_preimage_enum.sv
// Preimage enumerator for the m1_output_5 projection f(x0..x5): scans all 64
// input vectors in ascending order and streams every v with f(v) == target.
module m1_output_5_preimage_enum #(
    parameter int NIN  = 6,
    parameter int CNTW = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            target,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [NIN-1:0]  out_vec,
    output logic            busy,
    output logic            done,
    output logic [CNTW-1:0] match_cnt
);

    if (NIN != 6) begin : g_nin_check
        $error("m1_output_5_preimage_enum: NIN must be 6");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Projected function; x0 does not influence f, so only x1..x5 are passed.
    function automatic logic f_eval(input logic [4:0] x);
        logic x1, x2, x3, x4, x5;
        {x5, x4, x3, x2, x1} = x;
        if (x2) begin
            f_eval = x1 | (x3 ^ x4);
        end else begin
            f_eval = (x3 & ~x5) | ~(x4 ^ (x1 & ~(x3 ^ x4)));
        end
    endfunction

    localparam logic [NIN-1:0]  IDX_LAST = {NIN{1'b1}};
    localparam logic [NIN-1:0]  IDX_ONE  = {{(NIN-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] CNT_ONE  = {{(CNTW-1){1'b0}}, 1'b1};

    state_t          state_r, state_s;
    logic [NIN-1:0]  idx_r, idx_s;
    logic            tgt_r, tgt_s;
    logic [NIN-1:0]  vec_s;
    logic            valid_s;
    logic [CNTW-1:0] cnt_s;
    logic            busy_s, done_s;
    logic            slot_free_s, last_s, match_s;

    assign slot_free_s = !out_valid || out_ready;
    assign last_s      = (idx_r == IDX_LAST);
    assign match_s     = (f_eval(idx_r[NIN-1:1]) == tgt_r);

    // State register and registered datapath/outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            idx_r     <= '0;
            tgt_r     <= 1'b0;
            out_vec   <= '0;
            out_valid <= 1'b0;
            match_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            tgt_r     <= tgt_s;
            out_vec   <= vec_s;
            out_valid <= valid_s;
            match_cnt <= cnt_s;
            busy      <= busy_s;
            done      <= done_s;
        end
    end

    // Next-state logic; the scan leaves on idx 63 by state, never by wrapping.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) state_s = S_SCAN;
                else       state_s = S_IDLE;
            end
            S_SCAN: begin
                if (slot_free_s && last_s) state_s = S_DRAIN;
                else                       state_s = S_SCAN;
            end
            S_DRAIN: begin
                if (slot_free_s) state_s = S_DONE;
                else             state_s = S_DRAIN;
            end
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // Datapath/output next values; an occupied output slot freezes idx and out_vec.
    always_comb begin
        idx_s   = idx_r;
        tgt_s   = tgt_r;
        vec_s   = out_vec;
        valid_s = out_valid;
        cnt_s   = match_cnt;
        busy_s  = (state_s != S_IDLE);
        done_s  = (state_r == S_DONE);
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    tgt_s = target;
                    idx_s = '0;
                    cnt_s = '0;
                end else begin
                    tgt_s = tgt_r;
                end
            end
            S_SCAN: begin
                if (slot_free_s) begin
                    if (match_s) begin
                        vec_s   = idx_r;
                        valid_s = 1'b1;
                        cnt_s   = match_cnt + CNT_ONE;
                    end else begin
                        valid_s = 1'b0;
                    end
                    if (last_s) idx_s = idx_r;
                    else        idx_s = idx_r + IDX_ONE;
                end else begin
                    idx_s = idx_r;
                end
            end
            S_DRAIN: begin
                if (slot_free_s) valid_s = 1'b0;
                else             valid_s = out_valid;
            end
            S_DONE:  valid_s = 1'b0;
            default: valid_s = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_m1_output_5_preimage_enum.sv
// Directed bench for m1_output_5_preimage_enum: table-driven scans plus
// hand-written reset sequences, checked against an independent model of f.
module tb_m1_output_5_preimage_enum;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       target = 1'b0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [5:0] out_vec;
    logic       busy;
    logic       done;
    logic [6:0] match_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    m1_output_5_preimage_enum #(.NIN(6), .CNTW(7)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_vec   (out_vec),
        .busy      (busy),
        .done      (done),
        .match_cnt (match_cnt)
    );

    typedef struct {
        logic       tgt;
        bit         bp;      // random out_ready (~30% high)
        bit         glitch;  // start pulses and target toggle during the scan
        int         exp_cnt;
        logic [5:0] f0, f1, f2;
    } rec_t;

    rec_t        tbl[4];
    logic [63:0] seen_on, seen_off, seen_tmp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model written as equality tests rather than XOR chains.
    function automatic logic gold_f(input logic [5:0] v);
        logic x1, x2, x3, x4, x5;
        x1 = v[1]; x2 = v[2]; x3 = v[3]; x4 = v[4]; x5 = v[5];
        if (x2) return x1 || (x3 != x4);
        else    return (x3 && !x5) || (x4 == (x1 && (x3 == x4)));
    endfunction

    task automatic run_scan(input rec_t r, output logic [63:0] seen);
        logic [5:0] got[$];
        logic [5:0] exp[$];
        int         done_k = -1;
        bit         held = 1'b0;
        logic [5:0] held_vec = 6'd0;
        int         stab_err = 0;
        bit         rdy;
        seen = 64'd0;
        @(negedge clk);
        start = 1'b1; target = r.tgt; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (k == 0) chk("busy_after_start", {31'd0, busy}, 32'd1);
            if (held && (!out_valid || out_vec !== held_vec)) stab_err++;
            if (done) begin
                done_k = k;
                break;
            end
            start = r.glitch && (k == 20 || k == 65);
            if (r.glitch && k == 20) target = ~r.tgt;
            rdy = r.bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            out_ready = rdy;
            if (out_valid && rdy) begin
                got.push_back(out_vec);
                seen[out_vec] = 1'b1;
            end
            held     = out_valid && !rdy;
            held_vec = out_vec;
            @(negedge clk);
        end
        start = 1'b0; out_ready = 1'b1; target = r.tgt;
        chk("done_seen", {31'd0, done_k >= 0}, 32'd1);
        chk("valid_at_done", {31'd0, out_valid}, 32'd0);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        if (!r.bp) chk("done_latency", done_k, 32'd66);
        if (r.bp) chk("stable_under_bp", stab_err, 32'd0);
        chk("match_cnt", {25'd0, match_cnt}, r.exp_cnt);
        chk("emit_count", got.size(), r.exp_cnt);
        for (int v = 0; v < 64; v++) begin
            if (gold_f(6'(v)) == r.tgt) exp.push_back(6'(v));
        end
        chk("gold_count", exp.size(), r.exp_cnt);
        for (int i = 0; i < got.size() && i < exp.size(); i++) begin
            chk($sformatf("vec[%0d]", i), {26'd0, got[i]}, {26'd0, exp[i]});
        end
        if (got.size() >= 3) begin
            chk("first0", {26'd0, got[0]}, {26'd0, r.f0});
            chk("first1", {26'd0, got[1]}, {26'd0, r.f1});
            chk("first2", {26'd0, got[2]}, {26'd0, r.f2});
        end
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        repeat (5) @(negedge clk);
        chk("no_relaunch_busy", {31'd0, busy}, 32'd0);
        chk("cnt_held", {25'd0, match_cnt}, r.exp_cnt);
    endtask

    initial begin
        int n_emit;
        int done_hits;
        // 0x04 and 0x05 are OFF: with x2=1, x1=0 and x3==x4, f is 0.
        tbl[0] = '{1'b1, 1'b0, 1'b0, 42, 6'h00, 6'h01, 6'h06};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 22, 6'h02, 6'h03, 6'h04};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 42, 6'h00, 6'h01, 6'h06};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 42, 6'h00, 6'h01, 6'h06};

        // Asynchronous reset mid-cycle, well away from any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_vec", {26'd0, out_vec}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cnt", {25'd0, match_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
        chk("idle_valid", {31'd0, out_valid}, 32'd0);

        for (int t = 0; t < 4; t++) begin
            run_scan(tbl[t], seen_tmp);
            if (t == 0) seen_on = seen_tmp;
            if (t == 1) seen_off = seen_tmp;
        end
        chk("union_all", (seen_on | seen_off) == 64'hFFFF_FFFF_FFFF_FFFF ? 32'd1 : 32'd0, 32'd1);
        chk("no_overlap", (seen_on & seen_off) == 64'd0 ? 32'd1 : 32'd0, 32'd1);

        // Reset after the tenth accepted vector of an ON-set scan.
        @(negedge clk);
        start = 1'b1; target = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        n_emit = 0;
        for (int k = 0; k < 200; k++) begin
            if (out_valid) n_emit++;
            if (n_emit == 10) break;
            @(negedge clk);
        end
        chk("ten_emitted", n_emit, 32'd10);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_cnt", {25'd0, match_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        done_hits = 0;
        for (int k = 0; k < 6; k++) begin
            if (done || busy || out_valid) done_hits++;
            @(negedge clk);
        end
        chk("midrst_quiet", done_hits, 32'd0);
        run_scan(tbl[1], seen_tmp);
        chk("after_rst_offset", seen_tmp == seen_off ? 32'd1 : 32'd0, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
